// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next PC from increment, jump, relative
// branch, call or return, and keeps call return addresses on a small LIFO stack.
module pc_sequencer #(
  parameter int unsigned          PC_WIDTH     = 8,
  parameter int unsigned          OFS_WIDTH    = 8,
  parameter int unsigned          STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned          INC          = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               hold,
  input  logic                               jump_en,
  input  logic                               branch_en,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic [PC_WIDTH-1:0]                target,
  input  logic [OFS_WIDTH-1:0]               offset,
  input  logic                               err_clr,
  output logic [PC_WIDTH-1:0]                current_pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_count,
  output logic                               stk_full,
  output logic                               stk_empty,
  output logic [PC_WIDTH-1:0]                stk_top,
  output logic                               stk_err
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] ofs_ext;
  logic                err_set;
  logic                push;

  assign pc_inc  = pc_q + PC_WIDTH'(INC);
  // Sign-extend the branch offset to PC width; wrap in the adder is intentional.
  assign ofs_ext = PC_WIDTH'($signed(offset));

  assign current_pc = pc_q;
  assign stk_count  = cnt_q;
  assign stk_err    = err_q;
  assign stk_full   = (cnt_q == CW'(STACK_DEPTH));
  assign stk_empty  = (cnt_q == '0);

  // Top-of-stack mux from registered state; reads 0 when empty so stale
  // contents after reset never leak out.
  always_comb begin
    stk_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) stk_top = stack_q[i];
    end
  end

  // Next-state selection in priority order: hold > ret > call > jump > branch > inc.
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stack_d = stack_q;
    err_set = 1'b0;
    push    = 1'b0;
    if (!hold) begin
      pc_d = pc_inc;
      if (ret_en) begin
        if (stk_empty) begin
          err_set = 1'b1;
        end else begin
          pc_d  = stk_top;
          cnt_d = cnt_q - CW'(1);
        end
      end else if (call_en) begin
        if (stk_full) begin
          err_set = 1'b1;
        end else begin
          push  = 1'b1;
          pc_d  = target;
          cnt_d = cnt_q + CW'(1);
        end
      end else if (jump_en) begin
        pc_d = target;
      end else if (branch_en) begin
        pc_d = pc_q + ofs_ext;
      end
      // A new error wins over a simultaneous clear.
      if (err_set) begin
        err_d = 1'b1;
      end else if (err_clr) begin
        err_d = 1'b0;
      end
    end
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && cnt_q == CW'(i)) stack_d[i] = pc_inc;
    end
  end

  // State registers; stack contents are not reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack storage array.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with default parameters.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, hold, jump_en, branch_en, call_en, ret_en, err_clr;
  logic [7:0] target, offset;
  logic [7:0] current_pc, stk_top;
  logic [2:0] stk_count;
  logic       stk_full, stk_empty, stk_err;

  int tests = 0;
  int fails = 0;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .offset     (offset),
    .err_clr    (err_clr),
    .current_pc (current_pc),
    .stk_count  (stk_count),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_top    (stk_top),
    .stk_err    (stk_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; hold = 0; jump_en = 0; branch_en = 0; call_en = 0; ret_en = 0;
    err_clr = 0; target = 8'h00; offset = 8'h00;
  endtask

  // One clock edge, then settle before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [7:0] t);
    idle(); jump_en = 1; target = t; cycle(); idle();
  endtask

  task automatic do_call(input logic [7:0] t);
    idle(); call_en = 1; target = t; cycle(); idle();
  endtask

  task automatic do_ret();
    idle(); ret_en = 1; cycle(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; cycle(); idle();
    tests++; if (current_pc !== 8'h00) begin fails++; $display("FAIL reset_pc got %h want 00", current_pc); end
    tests++; if (stk_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", stk_count); end
    tests++; if (stk_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", stk_full); end
    tests++; if (stk_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", stk_empty); end
    tests++; if (stk_top !== 8'h00) begin fails++; $display("FAIL reset_top got %h want 00", stk_top); end
    tests++; if (stk_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", stk_err); end
  endtask

  task automatic test_increment();
    logic [7:0] exp;
    for (int k = 1; k <= 260; k++) begin
      cycle();
      exp = 8'(k);
      tests++;
      if (current_pc !== exp) begin
        fails++; $display("FAIL inc_pc cycle %0d got %h want %h", k, current_pc, exp);
      end
    end
    tests++; if (stk_err !== 1'b0) begin fails++; $display("FAIL inc_err got %b want 0", stk_err); end
    do_jump(8'h50);
    for (int k = 0; k < 3; k++) begin
      hold = 1; cycle();
      tests++;
      if (current_pc !== 8'h50) begin fails++; $display("FAIL hold_pc got %h want 50", current_pc); end
    end
    idle(); cycle();
    tests++; if (current_pc !== 8'h51) begin fails++; $display("FAIL hold_release got %h want 51", current_pc); end
  endtask

  task automatic test_branch();
    do_jump(8'h10);
    branch_en = 1; offset = 8'hFE; cycle(); idle();
    tests++; if (current_pc !== 8'h0E) begin fails++; $display("FAIL branch_back got %h want 0e", current_pc); end
    do_jump(8'hFF);
    branch_en = 1; offset = 8'h02; cycle(); idle();
    tests++; if (current_pc !== 8'h01) begin fails++; $display("FAIL branch_wrap got %h want 01", current_pc); end
    branch_en = 1; offset = 8'h80; cycle(); idle();
    tests++; if (current_pc !== 8'h81) begin fails++; $display("FAIL branch_neg_wrap got %h want 81", current_pc); end
    // Jump outranks branch.
    jump_en = 1; target = 8'h05; branch_en = 1; offset = 8'h10; cycle(); idle();
    tests++; if (current_pc !== 8'h05) begin fails++; $display("FAIL jump_over_branch got %h want 05", current_pc); end
  endtask

  task automatic test_back_to_back();
    do_jump(8'h20);
    do_call(8'h80);
    tests++; if (current_pc !== 8'h80) begin fails++; $display("FAIL call_pc got %h want 80", current_pc); end
    tests++; if (stk_top !== 8'h21) begin fails++; $display("FAIL call_top got %h want 21", stk_top); end
    tests++; if (stk_count !== 3'd1) begin fails++; $display("FAIL call_count got %0d want 1", stk_count); end
    do_ret();
    tests++; if (current_pc !== 8'h21) begin fails++; $display("FAIL ret_pc got %h want 21", current_pc); end
    tests++; if (stk_empty !== 1'b1) begin fails++; $display("FAIL ret_empty got %b want 1", stk_empty); end
    tests++; if (stk_top !== 8'h00) begin fails++; $display("FAIL ret_top got %h want 00", stk_top); end
  endtask

  task automatic test_overflow_underflow();
    logic [7:0] exp_pc [5];
    exp_pc[0] = 8'h39; exp_pc[1] = 8'h31; exp_pc[2] = 8'h21; exp_pc[3] = 8'h11; exp_pc[4] = 8'h12;
    do_jump(8'h10);
    do_call(8'h20);
    do_call(8'h30);
    do_call(8'h38);
    do_call(8'h40);
    tests++; if (stk_full !== 1'b1) begin fails++; $display("FAIL fill_full got %b want 1", stk_full); end
    tests++; if (stk_top !== 8'h39) begin fails++; $display("FAIL fill_top got %h want 39", stk_top); end
    do_call(8'h90);
    tests++; if (current_pc !== 8'h41) begin fails++; $display("FAIL ovf_pc got %h want 41", current_pc); end
    tests++; if (stk_count !== 3'd4) begin fails++; $display("FAIL ovf_count got %0d want 4", stk_count); end
    tests++; if (stk_err !== 1'b1) begin fails++; $display("FAIL ovf_err got %b want 1", stk_err); end
    err_clr = 1; cycle(); idle();
    tests++; if (stk_err !== 1'b0) begin fails++; $display("FAIL err_clr got %b want 0", stk_err); end
    for (int k = 0; k < 5; k++) begin
      do_ret();
      tests++;
      if (current_pc !== exp_pc[k]) begin
        fails++; $display("FAIL lifo_pop %0d got %h want %h", k, current_pc, exp_pc[k]);
      end
    end
    tests++; if (stk_err !== 1'b1) begin fails++; $display("FAIL unf_err got %b want 1", stk_err); end
    tests++; if (stk_count !== 3'd0) begin fails++; $display("FAIL unf_count got %0d want 0", stk_count); end
    // Set beats clear; hold blocks clear.
    ret_en = 1; err_clr = 1; cycle(); idle();
    tests++; if (stk_err !== 1'b1) begin fails++; $display("FAIL set_over_clr got %b want 1", stk_err); end
    tests++; if (current_pc !== 8'h13) begin fails++; $display("FAIL unf_pc got %h want 13", current_pc); end
    hold = 1; err_clr = 1; cycle(); idle();
    tests++; if (stk_err !== 1'b1) begin fails++; $display("FAIL hold_clr got %b want 1", stk_err); end
    err_clr = 1; cycle(); idle();
    tests++; if (stk_err !== 1'b0) begin fails++; $display("FAIL clr_after got %b want 0", stk_err); end
  endtask

  task automatic test_priority();
    do_jump(8'h32);
    do_call(8'h60);
    ret_en = 1; call_en = 1; jump_en = 1; target = 8'h77; cycle(); idle();
    tests++; if (current_pc !== 8'h33) begin fails++; $display("FAIL prio_pc got %h want 33", current_pc); end
    tests++; if (stk_count !== 3'd0) begin fails++; $display("FAIL prio_count got %0d want 0", stk_count); end
    do_call(8'h70);
    hold = 1; ret_en = 1; cycle(); idle();
    tests++; if (current_pc !== 8'h70) begin fails++; $display("FAIL hold_ret_pc got %h want 70", current_pc); end
    tests++; if (stk_count !== 3'd1) begin fails++; $display("FAIL hold_ret_count got %0d want 1", stk_count); end
    tests++; if (stk_top !== 8'h34) begin fails++; $display("FAIL hold_ret_top got %h want 34", stk_top); end
  endtask

  task automatic test_reset_mid();
    do_call(8'h80);
    do_call(8'h90);
    tests++; if (stk_count !== 3'd3) begin fails++; $display("FAIL pre_rst_count got %0d want 3", stk_count); end
    rst = 1; ret_en = 1; cycle(); idle();
    tests++; if (current_pc !== 8'h00) begin fails++; $display("FAIL rst_mid_pc got %h want 00", current_pc); end
    tests++; if (stk_count !== 3'd0) begin fails++; $display("FAIL rst_mid_count got %0d want 0", stk_count); end
    tests++; if (stk_top !== 8'h00) begin fails++; $display("FAIL rst_mid_top got %h want 00", stk_top); end
    tests++; if (stk_err !== 1'b0) begin fails++; $display("FAIL rst_mid_err got %b want 0", stk_err); end
    do_ret();
    tests++; if (current_pc !== 8'h01) begin fails++; $display("FAIL post_rst_unf_pc got %h want 01", current_pc); end
    tests++; if (stk_err !== 1'b1) begin fails++; $display("FAIL post_rst_unf_err got %b want 1", stk_err); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_increment();
    test_branch();
    test_back_to_back();
    test_overflow_underflow();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the soft processor. It holds the current PC and selects the next one from increment, absolute jump, PC-relative branch, subroutine call or return. An internal return-address stack of configurable depth stores call return addresses. It sits between instruction fetch (`current_pc` drives the instruction memory address) and the control unit (which drives the control strobes).

## Interface
Parameters:
- `PC_WIDTH`, 8: width of PC, jump target and stack entries.
- `OFS_WIDTH`, 8: width of the signed branch offset; must be ≤ `PC_WIDTH`.
- `STACK_DEPTH`, 4: return-stack entries, ≥ 1.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `INC`, 1: sequential increment.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `hold`, in, 1: stall; freezes PC and stack.
- `jump_en`, in, 1: absolute jump to `target`.
- `branch_en`, in, 1: relative branch by `offset`.
- `call_en`, in, 1: push return address, then jump to `target`.
- `ret_en`, in, 1: pop the return address into PC.
- `target`, in, PC_WIDTH: absolute destination for jump and call.
- `offset`, in, OFS_WIDTH: signed two's-complement branch offset.
- `err_clr`, in, 1: clears `stk_err`.
- `current_pc`, out, PC_WIDTH: registered PC.
- `stk_count`, out, clog2(STACK_DEPTH+1): number of occupied stack entries.
- `stk_full`, out, 1: `stk_count == STACK_DEPTH`.
- `stk_empty`, out, 1: `stk_count == 0`.
- `stk_top`, out, PC_WIDTH: top entry; 0 when the stack is empty.
- `stk_err`, out, 1: sticky overflow/underflow flag.

## Operation
- Per-edge priority: `rst` > `hold` > `ret_en` > `call_en` > `jump_en` > `branch_en` > increment. Only the highest-priority active request acts; lower ones are dropped, not queued.
- `rst`:
  - `current_pc` = `RESET_VECTOR`, `stk_count` = 0, `stk_err` = 0.
  - Stack contents are don't-care, but `stk_top` reads 0.
  - Reset mid-call or mid-return discards all stack state.
- `hold`: PC, stack, count and `stk_err` are all unchanged. `err_clr` is also ignored while `hold` is high.
- Increment: PC ← (PC + `INC`) mod 2^PC_WIDTH. Wrap from max to 0 is silent and does not set `stk_err`.
- Branch: PC ← (PC + sign-extended `offset`) mod 2^PC_WIDTH. Wrap in either direction is silent.
- Jump: PC ← `target`.
- Call:
  - Not full: push (PC + `INC`) mod 2^PC_WIDTH, count + 1, PC ← `target`.
  - Full (overflow): no push, PC increments normally, `stk_err` ← 1.
- Return:
  - Not empty: PC ← top entry, count − 1.
  - Empty (underflow): PC increments normally, `stk_err` ← 1.
- `ret_en` and `call_en` in the same cycle: the return acts and the call is dropped.
- `stk_err`: set has priority over `err_clr` in the same cycle; otherwise `err_clr` clears it.
- Stack is LIFO.
  - `stk_top`, `stk_full`, `stk_empty` are combinational from registered state, so they are valid in the same cycle the count changes.
  - No counter wrap: count stays within 0..STACK_DEPTH.

## Timing
- Single-cycle: controls are sampled at a rising edge and the new `current_pc` is visible right after that edge. Zero added latency relative to a plain registered PC.
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.
- Reset values: `current_pc` = `RESET_VECTOR`, `stk_count` = 0, `stk_full` = 0, `stk_empty` = 1, `stk_top` = 0, `stk_err` = 0.
- Back-to-back call then return on consecutive cycles is legal. The return sees the entry pushed on the previous edge.

## Test plan
- Defaults, reset then 260 cycles of increment → PC runs 0..255, wraps to 0 at cycle 256, `stk_err` stays 0; `hold` high for 3 cycles mid-run → PC frozen for exactly 3 cycles.
- PC = 0x10, `branch_en` with `offset` = 0xFE (−2) → 0x0E; PC = 0xFF, `offset` = 0x02 → 0x01.
- PC = 0x20, `call_en`, `target` = 0x80 → PC = 0x80, `stk_top` = 0x21, count 1; next cycle `ret_en` → PC = 0x21, `stk_empty` = 1.
- Fill with 4 calls, 5th call at PC = 0x40 → PC = 0x41, count stays 4, `stk_err` = 1; `err_clr` → 0; 5 returns pop in LIFO order, 5th return → underflow, `stk_err` = 1.
- Same cycle `ret_en` + `call_en` + `jump_en` with count 1, top = 0x33 → PC = 0x33, count 0, no push; `hold` + `ret_en` → no change.
- `rst` asserted with count 3, PC = 0x90 → next edge PC = `RESET_VECTOR`, count 0, `stk_err` 0; a subsequent `ret_en` → underflow.
